secret_mac_responder: RTL and testbench
=======================================

// Module: secret_mac_responder
// PURPOSE
// - Responder end of the a/b -> x operand interface: accepts operand pairs (a, b) via valid/ready, returns running
//   multiply-accumulate results x via valid/ready.
// - Sits below a testbench/stimulus driver on the same clk/reset_l; replaces fixed-timing operand sampling with
//   flow-controlled transfers and buffers results under backpressure.
// PARAMETERS
// - WIDTH       32  operand, accumulator and result width (bits)
// - FIFO_DEPTH  4   result FIFO entries, power of two, >= 2
// PORTS
// - clk        in   1             single clock, all state on rising edge
// - reset_l    in   1             asynchronous, active-low reset
// - in_valid   in   1             operand pair valid
// - in_ready   out  1             responder can accept operand pair
// - a          in   WIDTH         operand A, unsigned
// - b          in   WIDTH         operand B, unsigned
// - clear      in   1             qualified by in_valid&in_ready: restart accumulation with this pair
// - out_valid  out  1             result available at FIFO head
// - out_ready  in   1             consumer takes result
// - x          out  WIDTH         result at FIFO head; 0 when FIFO empty
// - ovf        out  1             sticky: an accumulate carried out of WIDTH bits
// - pending    out  $clog2(FIFO_DEPTH)+1  results in FIFO plus results in flight
// BEHAVIOUR
// - Reset (reset_l low, async assert, sync deassert at clk edge): acc=0, pipeline valids=0, FIFO empty, ovf=0;
//   outputs out_valid=0, x=0, pending=0, in_ready=1.
// - Accept when in_valid & in_ready at edge k. Edge k+1: stage-1 registers prod = (a*b) mod 2^WIDTH, clear bit.
//   Edge k+2: acc <= (clr ? 0 : acc) + prod, mod 2^WIDTH; new acc written into FIFO. out_valid visible after k+2.
//   Latency 2 cycles into an empty FIFO; one pair per cycle throughput.
// - ovf: set at edge k+2 when the unsigned add carries; cleared in the same update when clr=1 (ovf = carry of 0+prod=0).
// - in_ready = (fifo_count + inflight) < FIFO_DEPTH, combinational from registered state; no dependency on
//   in_valid or out_ready. Guarantees FIFO can never overflow; no result ever dropped.
// - FIFO: first-word fall-through; pop when out_valid & out_ready. Push and pop in the same edge: count unchanged,
//   legal at full and at count=1 (head advances to newly written entry only if it is the sole remaining one).
// - pending = fifo_count + number of valid pipeline stages; never exceeds FIFO_DEPTH.
// - out_valid & !out_ready: x held stable until popped. out_ready with FIFO empty: no effect.
// - a, b, clear ignored when not accepted; clear never affects in-flight results.
// - reset_l asserted mid-operation: in-flight and buffered results discarded, acc/ovf cleared immediately.
// STRUCTURE
// - secret_pkg: WIDTH_DEFAULT=32, FIFO_DEPTH_DEFAULT=4, typedef struct packed {logic clr; logic [WIDTH-1:0] prod;}
//   stage1_t.
// - One sub-module: secret_result_fifo (FWFT sync FIFO, params WIDTH/DEPTH, push/pop/count/head, async active-low reset).
// - Top: 2-stage MAC pipeline, acc/ovf registers, in_ready/pending credit logic.
// TESTING
// - Basic: out_ready=1; pairs (5,7),(6,2),(1,9), first with clear -> x=35,47,56 in order, each 2 cycles after accept.
// - Backpressure: out_ready=0, in_valid=1 with (1,1) continuously -> exactly 4 accepted, in_ready=0, pending=4;
//   then out_ready=1 -> x=1,2,3,4 popped, in_ready returns 1 the cycle after the first pop.
// - Clear: after x=56, accept (3,3) with clear=1 -> x=9; next (2,2) clear=0 -> x=13.
// - Wrap/ovf: clear with (0xFFFF,0x10001) -> x=0xFFFFFFFF, ovf=0; then (1,1) -> x=0, ovf=1; clear with (2,0) -> x=0,
//   ovf=0.
// - Simultaneous push/pop at full: FIFO full, out_ready=1 and in_valid=1 streaming -> pending stays <=4, no loss,
//   results strictly in accept order.
// - Reset mid-op: 3 pairs in flight/buffered, pulse reset_l low between edges -> out_valid=0, x=0, pending=0, ovf=0
//   immediately; next (5,7) without clear -> x=35.

Source files
------------

// File: rtl/secret_pkg.sv
// Shared definitions for the secret MAC responder slice.
// Provides default sizing, the stage-1 pipeline payload type and a helper
// that sizes occupancy counters for a given FIFO depth.
package secret_pkg;

    localparam int WIDTH_DEFAULT      = 32;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    // Payload held between the multiply and accumulate stages.
    typedef struct packed {
        logic                     clr;
        logic [WIDTH_DEFAULT-1:0] prod;
    } stage1_t;

    // Bits needed to count 0..depth inclusive (depth is a power of two).
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/secret_result_fifo.sv
// First-word fall-through synchronous FIFO holding accumulated results.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   push       write push_data this edge (ignored when full unless popping)
//   push_data  value to enqueue
//   pop        dequeue head this edge (ignored when empty)
//   count      number of stored entries, 0..DEPTH
//   head       oldest entry, 0 when empty
module secret_result_fifo
    import secret_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic [WIDTH-1:0]            head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_s;
    logic             push_s;

    // Qualify requests: pop needs data; push needs room, or a slot freed by a pop in the same edge.
    always_comb begin
        pop_s  = pop && (count_r != '0);
        push_s = push && ((count_r != CNT_FULL) || pop_s);
    end

    // Storage, pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Fall-through head; forced to zero when nothing is stored.
    always_comb begin
        count = count_r;
        if (count_r != '0) begin
            head = mem_r[rd_ptr_r];
        end else begin
            head = '0;
        end
    end

endmodule

// File: rtl/secret_mac_responder.sv
// Responder end of the a/b -> x operand interface.
// Accepts unsigned operand pairs with valid/ready, multiplies them, adds the
// product into a running accumulator and returns every new accumulator value
// through a result FIFO with valid/ready.
// Ports:
//   clk, reset_l          clock and asynchronous active-low reset
//   in_valid/in_ready     operand handshake; a, b, clear captured on transfer
//   clear                 restart accumulation from this pair
//   out_valid/out_ready   result handshake; x is the FIFO head (0 when empty)
//   ovf                   sticky carry-out of the accumulator since last clear
//   pending               buffered plus in-flight results
module secret_mac_responder
    import secret_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                                clk,
    input  logic                                reset_l,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH-1:0]                    a,
    input  logic [WIDTH-1:0]                    b,
    input  logic                                clear,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WIDTH-1:0]                    x,
    output logic                                ovf,
    output logic [cnt_width(FIFO_DEPTH)-1:0]    pending
);

    localparam int CW = cnt_width(FIFO_DEPTH);
    localparam logic [CW:0] OCC_LIMIT = (CW+1)'(FIFO_DEPTH);

    // Stage 0: captured operands. Stage 1: product. Accumulate happens leaving stage 1.
    logic             s0_valid_r;
    logic             s0_clr_r;
    logic [WIDTH-1:0] s0_a_r;
    logic [WIDTH-1:0] s0_b_r;
    logic             s1_valid_r;
    logic             s1_clr_r;
    logic [WIDTH-1:0] s1_prod_r;
    logic [WIDTH-1:0] acc_r;
    logic             ovf_r;

    logic             accept_s;
    logic [WIDTH:0]   sum_s;
    logic [CW-1:0]    fifo_count_s;
    logic [CW-1:0]    inflight_s;
    logic [CW:0]      occupancy_s;
    logic [WIDTH-1:0] head_s;

    // Credit check counts every result already committed to a FIFO slot, so a push never finds it full.
    always_comb begin
        inflight_s  = CW'(s0_valid_r) + CW'(s1_valid_r);
        occupancy_s = {1'b0, fifo_count_s} + {1'b0, inflight_s};
        in_ready    = (occupancy_s < OCC_LIMIT);
        accept_s    = in_valid && in_ready;
        pending     = occupancy_s[CW-1:0];
    end

    // Accumulator next value with carry; a clearing pair starts from zero so it can never carry.
    always_comb begin
        if (s1_clr_r) begin
            sum_s = {1'b0, s1_prod_r};
        end else begin
            sum_s = {1'b0, acc_r} + {1'b0, s1_prod_r};
        end
    end

    // Two-stage MAC pipeline plus accumulator and sticky overflow.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            s0_valid_r <= 1'b0;
            s0_clr_r   <= 1'b0;
            s0_a_r     <= '0;
            s0_b_r     <= '0;
            s1_valid_r <= 1'b0;
            s1_clr_r   <= 1'b0;
            s1_prod_r  <= '0;
            acc_r      <= '0;
            ovf_r      <= 1'b0;
        end else begin
            s0_valid_r <= accept_s;
            if (accept_s) begin
                s0_a_r   <= a;
                s0_b_r   <= b;
                s0_clr_r <= clear;
            end
            s1_valid_r <= s0_valid_r;
            if (s0_valid_r) begin
                s1_prod_r <= s0_a_r * s0_b_r;
                s1_clr_r  <= s0_clr_r;
            end
            if (s1_valid_r) begin
                acc_r <= sum_s[WIDTH-1:0];
                ovf_r <= s1_clr_r ? 1'b0 : (ovf_r | sum_s[WIDTH]);
            end
        end
    end

    secret_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset_l),
        .push      (s1_valid_r),
        .push_data (sum_s[WIDTH-1:0]),
        .pop       (out_ready),
        .count     (fifo_count_s),
        .head      (head_s)
    );

    // Result side is a direct view of the FIFO registers.
    always_comb begin
        out_valid = (fifo_count_s != '0);
        x         = head_s;
        ovf       = ovf_r;
    end

endmodule

// File: tb/tb_secret_mac_responder.sv
// Self-checking bench for secret_mac_responder: directed scenarios with
// hand-computed results plus randomized traffic against a queue-based model.
module tb_secret_mac_responder;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        clear = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] x;
    logic        ovf;
    logic [2:0]  pending;

    int vectors = 0;
    int errors  = 0;
    logic chk_en = 1'b0;

    secret_mac_responder dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .ovf       (ovf),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Each accepted pair becomes a result whose value is known at accept time;
    // it becomes visible two edges later and leaves when popped.
    typedef struct {
        int          due;
        logic [31:0] val;
        logic        ovf;
    } ent_t;

    ent_t        pipe_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] popped_q[$];
    logic [31:0] m_acc = 32'h0;
    logic        m_chain_ovf = 1'b0;
    logic        m_ovf = 1'b0;
    int          cyc = 0;
    int          accepted = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model reset: everything in flight or buffered is discarded.
    always @(negedge reset_l) begin
        pipe_q.delete();
        fifo_q.delete();
        m_acc       = 32'h0;
        m_chain_ovf = 1'b0;
        m_ovf       = 1'b0;
    end

    // Model advance at each rising edge.
    always @(posedge clk) begin
        if (reset_l) begin
            int          occ;
            logic        acc_ev;
            logic        pop_ev;
            logic [63:0] p;
            logic [32:0] s;
            ent_t        e;
            occ    = pipe_q.size() + fifo_q.size();
            acc_ev = in_valid && (occ < D);
            pop_ev = out_ready && (fifo_q.size() > 0);
            if (pop_ev) popped_q.push_back(fifo_q.pop_front());
            cyc++;
            while (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
                e = pipe_q.pop_front();
                fifo_q.push_back(e.val);
                m_ovf = e.ovf;
            end
            if (acc_ev) begin
                p = {32'h0, a} * {32'h0, b};
                s = (clear ? 33'h0 : {1'b0, m_acc}) + {1'b0, p[31:0]};
                m_acc = s[31:0];
                m_chain_ovf = clear ? 1'b0 : (m_chain_ovf | s[32]);
                e.due = cyc + 2;
                e.val = s[31:0];
                e.ovf = m_chain_ovf;
                pipe_q.push_back(e);
                accepted++;
            end
        end
    end

    // Compare process: every output against the model on every active cycle.
    always @(negedge clk) begin
        if (chk_en && reset_l) begin
            int occ;
            occ = pipe_q.size() + fifo_q.size();
            chk("in_ready", 32'(in_ready), 32'(occ < D));
            chk("out_valid", 32'(out_valid), 32'(fifo_q.size() > 0));
            chk("x", x, (fifo_q.size() > 0) ? fifo_q[0] : 32'h0);
            chk("pending", 32'(pending), 32'(occ));
            chk("ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic cv);
        logic done;
        done = 1'b0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        clear = cv;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) done = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: got no accept within 50 cycles, required accept");
        end
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        clear = $urandom_range(0, 1) == 1;
    endtask

    task automatic expect_pops(input string name, input int n, input logic [31:0] v0,
                               input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] v3);
        logic [31:0] ev [4];
        ev[0] = v0; ev[1] = v1; ev[2] = v2; ev[3] = v3;
        chk({name, "_count"}, 32'(popped_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk(name, (i < popped_q.size()) ? popped_q[i] : 32'hDEAD_BEEF, ev[i]);
        end
        popped_q.delete();
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        int base;
        idle(3);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_x", x, 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        reset_l = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Basic accumulation
        out_ready = 1'b1;
        send(32'd5, 32'd7, 1'b1);
        send(32'd6, 32'd2, 1'b0);
        send(32'd1, 32'd9, 1'b0);
        idle(5);
        expect_pops("basic", 3, 32'd35, 32'd47, 32'd56, 32'd0);

        // Clear restarts accumulation
        send(32'd3, 32'd3, 1'b1);
        send(32'd2, 32'd2, 1'b0);
        idle(5);
        expect_pops("clear", 2, 32'd9, 32'd13, 32'd0, 32'd0);

        // Backpressure fills exactly FIFO_DEPTH
        out_ready = 1'b0;
        base = accepted;
        in_valid = 1'b1; a = 32'd1; b = 32'd1; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        idle(7);
        in_valid = 1'b0;
        chk("bp_accepted", 32'(accepted - base), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_pending", 32'(pending), 32'd4);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        idle(6);
        expect_pops("bp", 4, 32'd1, 32'd2, 32'd3, 32'd4);

        // Wrap and overflow
        send(32'h0000_FFFF, 32'h0001_0001, 1'b1);
        idle(4);
        chk("wrap_ovf0", 32'(ovf), 32'd0);
        expect_pops("wrap_a", 1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
        send(32'd1, 32'd1, 1'b0);
        idle(4);
        chk("wrap_ovf1", 32'(ovf), 32'd1);
        expect_pops("wrap_b", 1, 32'd0, 32'd0, 32'd0, 32'd0);
        send(32'd2, 32'd0, 1'b1);
        idle(4);
        chk("wrap_ovf_clr", 32'(ovf), 32'd0);
        expect_pops("wrap_c", 1, 32'd0, 32'd0, 32'd0, 32'd0);

        // Streaming through a full FIFO
        out_ready = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < 26; i++) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom_range(0, 1000);
            if (i == 6) out_ready = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        idle(8);
        popped_q.delete();

        // Reset mid-operation
        out_ready = 1'b0;
        send(32'h8000_0000, 32'd1, 1'b1);
        send(32'h8000_0000, 32'd1, 1'b0);
        send(32'h0000_0003, 32'd1, 1'b0);
        idle(2);
        chk("pre_rst_ovf", 32'(ovf), 32'd1);
        chk("pre_rst_pending", 32'(pending), 32'd3);
        #2 reset_l = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_x", x, 32'd0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        #1 reset_l = 1'b1;
        @(negedge clk);
        popped_q.delete();
        out_ready = 1'b1;
        send(32'd5, 32'd7, 1'b0);
        idle(4);
        expect_pops("post_rst", 1, 32'd35, 32'd0, 32'd0, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            clear     = $urandom_range(0, 7) == 0;
            out_ready = (i % 200 < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom;
                b = $urandom;
            end else begin
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 15);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(10);
        popped_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
